// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer and the hazard/decode logic.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_FIXUP = 2'b10
    } state_e;

    // MIPS SPECIAL funct codes for HI/LO moves and mul/div
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

endpackage

// File: rtl/muldiv_step.sv
// One iteration: shift-add (multiply, LSB-first) or restoring shift-subtract (divide).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0] add_s;
    logic [WIDTH:0] rem_sh_s;
    logic [WIDTH:0] diff_s;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        add_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        rem_sh_s = acc[2*WIDTH-1:WIDTH-1];
        diff_s   = rem_sh_s - {1'b0, operand};
        acc_next = acc;
        if (is_div) begin
            if (!diff_s[WIDTH]) begin
                acc_next = {diff_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else if (acc[0]) begin
            acc_next = {add_s, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Optional MULDIV_EARLY_TERM_EN: multiply leaves RUN once the remaining multiplier bits are zero.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MoveReq,
    input  logic             MtHi,
    input  logic             MtLo,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Stall,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH);

    state_e               state_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   step_s;
    logic [2*WIDTH-1:0]   fix_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     operand_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic [WIDTH-1:0]     quo_s;
    logic [WIDTH-1:0]     rem_s;
    logic [WIDTH-1:0]     res_hi_s;
    logic [WIDTH-1:0]     res_lo_s;
    logic [WIDTH-1:0]     a_mag_s;
    logic [WIDTH-1:0]     b_mag_s;
    logic [CW-1:0]        count_r;
    logic                 is_div_r;
    logic                 neg_lo_r;
    logic                 neg_hi_r;
    logic                 busy_r;
    logic                 dbz_r;
    logic                 op_div_s;
    logic                 op_signed_s;
    logic                 run_done_s;

    // The magnitude of the most-negative value is itself when read as unsigned
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        magnitude = (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1'b1)) : v;
    endfunction

    // Operation decode and operand magnitudes
    always_comb begin
        op_div_s    = (Op == OP_DIV) || (Op == OP_DIVU);
        op_signed_s = (Op == OP_MULT) || (Op == OP_DIV);
        a_mag_s     = magnitude(A, op_signed_s);
        b_mag_s     = magnitude(B, op_signed_s);
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_r),
        .acc      (acc_r),
        .operand  (operand_r),
        .acc_next (step_s)
    );

`ifdef MULDIV_EARLY_TERM_EN
    logic [WIDTH-1:0] mask_s;

    // count_r equals the number of multiplier bits still unshifted after this step
    always_comb begin
        mask_s     = (WIDTH'(1'b1) << count_r) - WIDTH'(1'b1);
        run_done_s = (count_r == {CW{1'b0}}) ||
                     (!is_div_r && ((step_s[WIDTH-1:0] & mask_s) == {WIDTH{1'b0}}));
        fix_s      = acc_r >> count_r;
    end
`else
    // Fixed iteration count for every operation
    always_comb begin
        run_done_s = (count_r == {CW{1'b0}});
        fix_s      = acc_r;
    end
`endif

    // Sign correction and result selection for FIXUP
    always_comb begin
        prod_s = neg_lo_r ? -fix_s : fix_s;
        quo_s  = neg_lo_r ? -fix_s[WIDTH-1:0] : fix_s[WIDTH-1:0];
        rem_s  = neg_hi_r ? -fix_s[2*WIDTH-1:WIDTH] : fix_s[2*WIDTH-1:WIDTH];
        if (is_div_r) begin
            res_hi_s = rem_s;
            res_lo_s = quo_s;
        end else begin
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Sequencer FSM, HI/LO ownership and registered status outputs
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_r   <= S_IDLE;
            acc_r     <= {(2*WIDTH){1'b0}};
            operand_r <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            count_r   <= {CW{1'b0}};
            is_div_r  <= 1'b0;
            neg_lo_r  <= 1'b0;
            neg_hi_r  <= 1'b0;
            busy_r    <= 1'b0;
            dbz_r     <= 1'b0;
        end else begin
            dbz_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (Start && op_div_s && (B == {WIDTH{1'b0}})) begin
                        hi_r  <= A;
                        lo_r  <= {WIDTH{1'b1}};
                        dbz_r <= 1'b1;
                    end else if (Start) begin
                        acc_r     <= {{WIDTH{1'b0}}, (op_div_s ? a_mag_s : b_mag_s)};
                        operand_r <= op_div_s ? b_mag_s : a_mag_s;
                        is_div_r  <= op_div_s;
                        neg_lo_r  <= op_signed_s & (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_hi_r  <= op_signed_s & op_div_s & A[WIDTH-1];
                        count_r   <= CW'(WIDTH - 1);
                        busy_r    <= 1'b1;
                        state_r   <= S_RUN;
                    end else begin
                        if (MtHi) hi_r <= A;
                        if (MtLo) lo_r <= A;
                    end
                end
                S_RUN: begin
                    acc_r   <= step_s;
                    count_r <= run_done_s ? count_r : count_r - CW'(1'b1);
                    if (run_done_s) state_r <= S_FIXUP;
                end
                S_FIXUP: begin
                    hi_r    <= res_hi_s;
                    lo_r    <= res_lo_s;
                    count_r <= {CW{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign Hi        = hi_r;
    assign Lo        = lo_r;
    assign Busy      = busy_r;
    assign DivByZero = dbz_r;
    assign Stall     = busy_r & (MoveReq | Start);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: arithmetic reference model, decoupled result monitor.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int WIDTH      = 32;
    localparam int RUN_CYCLES = WIDTH + 1;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] A = 32'h0;
    logic [31:0] B = 32'h0;
    logic        MoveReq = 1'b0;
    logic        MtHi = 1'b0;
    logic        MtLo = 1'b0;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Stall;
    logic        DivByZero;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic mon_prev_busy = 1'b0;
    int   mon_busy_cnt = 0;

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .MoveReq(MoveReq), .MtHi(MtHi), .MtLo(MtLo),
        .Hi(Hi), .Lo(Lo), .Busy(Busy), .Stall(Stall), .DivByZero(DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Reference: plain 64-bit arithmetic, MIPS HI/LO semantics
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.dbz = 1'b0;
        e.hi  = 32'h0;
        e.lo  = 32'h0;
        if (op[1] && b == 32'h0) begin
            e.dbz = 1'b1;
            e.hi  = a;
            e.lo  = 32'hFFFF_FFFF;
        end else if (op == 2'b00) begin
            p = sa * sb;
            {e.hi, e.lo} = p;
        end else if (op == 2'b01) begin
            p = {32'h0, a} * {32'h0, b};
            {e.hi, e.lo} = p;
        end else if (op == 2'b10) begin
            q = sa / sb;
            r = sa % sb;
            e.lo = q[31:0];
            e.hi = r[31:0];
        end else begin
            q = {32'h0, a} / {32'h0, b};
            r = {32'h0, a} % {32'h0, b};
            e.lo = q[31:0];
            e.hi = r[31:0];
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 200) begin
            tick();
            n++;
        end
        if (Busy) check("idle_timeout", 32'(Busy), 32'h0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        Op = op;
        A = a;
        B = b;
        Start = 1'b1;
        exp_q.push_back(model(op, a, b));
        tick();
        Start = 1'b0;
    endtask

    // Monitor: pops the scoreboard on each DivByZero pulse or Busy falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Rst) begin
                mon_prev_busy = 1'b0;
                mon_busy_cnt  = 0;
                exp_q.delete();
            end else begin
                if (DivByZero || (mon_prev_busy && !Busy)) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 32'h1, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_kind", 32'(DivByZero), 32'(e.dbz));
                        check("hi", Hi, e.hi);
                        check("lo", Lo, e.lo);
                        if (DivByZero) check("dbz_busy", 32'(Busy), 32'h0);
                        else check("busy_len", 32'(mon_busy_cnt), 32'(RUN_CYCLES));
                    end
                end
                if (Busy) mon_busy_cnt++;
                else mon_busy_cnt = 0;
                mon_prev_busy = Busy;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] v;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rop;

        MoveReq = 1'b1;
        tick();
        tick();
        #1;
        check("reset_hi", Hi, 32'h0);
        check("reset_lo", Lo, 32'h0);
        check("reset_busy", 32'(Busy), 32'h0);
        check("reset_dbz", 32'(DivByZero), 32'h0);
        check("reset_stall", 32'(Stall), 32'h0);
        MoveReq = 1'b0;
        Rst = 1'b1;
        tick();

        // MULT with an MFHI waiting in ID; an MTHI slipped in mid-run must be ignored
        issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
        MoveReq = 1'b1;
        n = 0;
        while (Busy && n < 100) begin
            #1;
            check("stall_busy", 32'(Stall), 32'h1);
            MtHi = (n == 5);
            A = 32'hDEAD_BEEF;
            tick();
            n++;
        end
        MtHi = 1'b0;
        #1;
        check("stall_release", 32'(Stall), 32'h0);
        check("stall_len", 32'(n), 32'(RUN_CYCLES));
        MoveReq = 1'b0;

        issue(OP_DIVU, 32'd100, 32'd7);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

        // Start and MTHI together: the move loses, HI keeps 0 from the previous DIV
        MtHi = 1'b1;
        issue(OP_MULTU, 32'd3, 32'd5);
        MtHi = 1'b0;
        #1;
        check("start_beats_mthi", Hi, 32'h0);

        issue(OP_DIV, 32'd5, 32'd0);
        tick();
        check("dbz_pulse_len", 32'(DivByZero), 32'h0);
        check("dbz_busy_after", 32'(Busy), 32'h0);

        // Back-to-back: second op held by Stall, accepted once on the first IDLE cycle
        issue(OP_MULTU, 32'h0001_0000, 32'h0003_0000);
        Start = 1'b1;
        Op = OP_DIVU;
        A = 32'd1000;
        B = 32'd33;
        exp_q.push_back(model(OP_DIVU, 32'd1000, 32'd33));
        n = 0;
        while (Busy && n < 100) begin
            #1;
            check("b2b_stall", 32'(Stall), 32'h1);
            tick();
            n++;
        end
        #1;
        check("b2b_idle_stall", 32'(Stall), 32'h0);
        tick();
        Start = 1'b0;
        #1;
        check("b2b_accepted", 32'(Busy), 32'h1);
        wait_idle();
        tick();
        check("b2b_once", 32'(Busy), 32'h0);

        // Reset in the middle of RUN, then MTHI
        issue(OP_MULT, 32'h1234_5678, 32'h8765_4321);
        repeat (9) tick();
        Rst = 1'b0;
        tick();
        check("midrst_busy", 32'(Busy), 32'h0);
        check("midrst_hi", Hi, 32'h0);
        check("midrst_lo", Lo, 32'h0);
        Rst = 1'b1;
        MtHi = 1'b1;
        A = 32'h0000_1234;
        tick();
        MtHi = 1'b0;
        check("mthi_hi", Hi, 32'h0000_1234);
        check("mthi_lo", Lo, 32'h0);

        // Randomized operations with biased corner operands and occasional MTLO
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            issue(rop, ra, rb);
            if ($urandom_range(0, 4) == 0) begin
                wait_idle();
                tick();
                v = $urandom;
                MtLo = 1'b1;
                A = v;
                tick();
                MtLo = 1'b0;
                check("mtlo_lo", Lo, v);
            end
        end

        wait_idle();
        tick();
        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide controller and datapath for the EX stage.
- Executes MULT, MULTU, DIV and DIVU as one bit per cycle, and owns the architectural HI/LO registers.
- Raises Stall toward the hazard/stall logic when an MFHI/MFLO or a new mul/div reaches it while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Rst  in  1  synchronous active-low reset; sampled on the rising edge of Clk.
- Start  in  1  mul/div instruction valid in EX (already qualified by flush).
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  in  WIDTH  rs operand (multiplicand/dividend).
- B  in  WIDTH  rt operand (multiplier/divisor).
- MoveReq  in  1  MFHI/MFLO present in ID.
- MtHi  in  1  MTHI in EX.
- MtLo  in  1  MTLO in EX.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.
- Busy  out  1  operation in flight.
- Stall  out  1  freeze PC and IF/ID; bubble into EX.
- DivByZero  out  1  one-cycle pulse on DIV/DIVU with B==0.

Behaviour:
- Reset (Rst==0 at a rising edge) forces the following, including mid-operation; the in-flight operation is discarded:
  - state IDLE;
  - Hi=0, Lo=0;
  - Busy=0, DivByZero=0;
  - counter=0.
- FSM states: IDLE, RUN, FIXUP.
- IDLE, Start=1, Op=mul:
  - capture |A| and |B| for signed ops, raw values for unsigned;
  - record the result sign (A[msb]^B[msb] for signed, else 0);
  - clear the accumulator; counter=WIDTH-1; go to RUN.
- IDLE, Start=1, Op=div, B!=0:
  - capture |A| and |B|;
  - record quotient sign A^B and remainder sign A[msb];
  - remainder=0; go to RUN.
- IDLE, Start=1, Op=div, B==0:
  - no RUN; next edge Hi<=A, Lo<={WIDTH{1}};
  - DivByZero=1 for that one cycle; stay IDLE.
- RUN, multiply: shift-add on the 2*WIDTH product register, LSB-first multiplier.
- RUN, divide: restoring shift-subtract, one quotient bit per cycle.
- RUN exits to FIXUP when counter reaches 0; the counter decrements each cycle.
- FIXUP:
  - apply two's-complement negation per the recorded signs;
  - mul: Hi<=product[2W-1:W], Lo<=product[W-1:0];
  - div: Lo<=quotient, Hi<=remainder;
  - go to IDLE.
- Latency:
  - Start sampled at edge 0, RUN spans edges 1..WIDTH, FIXUP writes Hi/Lo at edge WIDTH+1;
  - Busy=1 from edge 0 through edge WIDTH+1;
  - results are visible with Busy=0 after edge WIDTH+1, i.e. WIDTH+1 cycles after Start.
- Busy is high whenever the state is not IDLE.
- Stall = Busy & (MoveReq | Start), combinational:
  - a second mul/div is held in EX by the stall and accepted on the first IDLE cycle;
  - MFHI/MFLO waits for the result.
- MtHi/MtLo:
  - in IDLE, write A into Hi/Lo at the next edge;
  - ignored while Busy; the pipeline cannot deliver them then, because MTHI/MTLO are treated as moves and stalled via MoveReq upstream.
- Start together with MtHi/MtLo in the same cycle: Start wins, the move is ignored.
- Most-negative operands:
  - the magnitude of 0x80000000 is 0x80000000 unsigned, which is correct;
  - DIV 0x80000000 / -1 yields Lo=0x80000000, Hi=0 (wraps, no trap).
- Hi/Lo hold their values in all cases not listed above.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: in a multiply, RUN exits to FIXUP as soon as the remaining unshifted multiplier bits are all zero. The product is realigned in FIXUP by shifting right by the remaining count, so latency varies from 2 to WIDTH+1 cycles. Divide is unchanged.
- Undefined: fixed WIDTH iterations for all ops. The realign logic and zero-detect are absent.

Decomposition:
- Shared package muldiv_pkg holds:
  - Op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - state encodings S_IDLE/S_RUN/S_FIXUP;
  - the MIPS funct codes 0x18–0x1B (mul/div) and 0x10–0x13 (MFHI/MTHI/MFLO/MTLO), which the hazard/decode logic also uses.
- Sub-module muldiv_step: one combinational iteration that takes mode and the partial product/remainder and returns the next value.

Test Plan:
- MULT A=7, B=0xFFFFFFFD: Busy high for 33 cycles, then Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; DivByZero stays 0.
- DIVU A=100, B=7: Lo=14, Hi=2 after 33 cycles; MULTU 0xFFFFFFFF*0xFFFFFFFF gives Hi=0xFFFFFFFE, Lo=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2: Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF gives Lo=0x80000000, Hi=0.
- DIV A=5, B=0: DivByZero pulses one cycle, Busy never rises, Hi=5, Lo=0xFFFFFFFF next cycle.
- MoveReq=1 on the cycle after a MULT start: Stall=1 for every Busy cycle, drops in the first cycle after FIXUP. A back-to-back Start is accepted exactly once, then runs a full 33-cycle sequence.
- Rst=0 at RUN cycle 10: the next edge gives Busy=0, Hi=Lo=0, state IDLE. A subsequent MTHI A=0x1234 gives Hi=0x1234.
